multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller.
// Moore FSM sequencing fetch, decode, memory access, execute and writeback
// steps, producing datapath enables and mux selects for each state.
// Handshake-dependent enables (IRWrite, PCWrite in FETCH, done in MEMWRITE)
// also look at mem_ready so they fire only in the cycle the access completes.
// Reset is asynchronous and active-high, and masks every output immediately.

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       done,
    output logic       illegal,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Mux select encodings, named for readability in the output table
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_REG    = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // Unmasked control values produced by the state decode
    logic       pc_update;
    logic       branch;
    logic       adr_src_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;
    logic       illegal_raw;
    logic [1:0] result_src_raw;
    logic [1:0] alu_src_a_raw;
    logic [1:0] alu_src_b_raw;
    logic [1:0] alu_op_raw;
    logic       pc_write_raw;

    // State register; reset returns the controller to FETCH without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: memory states wait on mem_ready, ILLEGAL only leaves via reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state output table; everything defaults to zero and each state sets only its own controls
    always_comb begin
        pc_update      = 1'b0;
        branch         = 1'b0;
        adr_src_raw    = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        done_raw       = 1'b0;
        illegal_raw    = 1'b0;
        result_src_raw = RES_ALUOUT;
        alu_src_a_raw  = SRCA_PC;
        alu_src_b_raw  = SRCB_REG;
        alu_op_raw     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b_raw  = SRCB_FOUR;
                result_src_raw = RES_ALU;
                ir_write_raw   = mem_ready;
                pc_update      = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_raw = SRCA_OLDPC;
                alu_src_b_raw = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a_raw = SRCA_REG;
                alu_src_b_raw = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src_raw = 1'b1;
            end
            S_MEMWB: begin
                result_src_raw = RES_DATA;
                reg_write_raw  = 1'b1;
                done_raw       = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_raw   = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a_raw = SRCA_REG;
                alu_op_raw    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a_raw = SRCA_REG;
                alu_src_b_raw = SRCB_IMM;
                alu_op_raw    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_JAL: begin
                alu_src_a_raw = SRCA_OLDPC;
                alu_src_b_raw = SRCB_FOUR;
                pc_update     = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_raw = SRCA_REG;
                alu_op_raw    = ALUOP_SUB;
                branch        = 1'b1;
                done_raw      = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_raw = 1'b1;
            end
            default: begin
                illegal_raw = 1'b0;
            end
        endcase
    end

    // PC is written on unconditional updates or on a taken branch
    always_comb begin
        pc_write_raw = pc_update | (branch & Zero);
    end

    // Output stage: reset masks all controls at once so nothing leaks before the clock arrives
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        if (!rst) begin
            PCWrite   = pc_write_raw;
            AdrSrc    = adr_src_raw;
            MemWrite  = mem_write_raw;
            IRWrite   = ir_write_raw;
            RegWrite  = reg_write_raw;
            done      = done_raw;
            illegal   = illegal_raw;
            ResultSrc = result_src_raw;
            ALUSrcA   = alu_src_a_raw;
            ALUSrcB   = alu_src_b_raw;
            ALUOp     = alu_op_raw;
        end
    end

    // Debug view of the current state
    always_comb begin
        state = state_q;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller.
// Each instruction is expanded by a reference model into its expected
// cycle-by-cycle observation list; the driver plays the list and queues the
// expectations, and a negedge monitor pops and compares them independently.

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       dn;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] aop;
    } obs_t;

    typedef struct packed {
        logic mr;
        logic z;
        obs_t o;
    } step_t;

    obs_t  exp_q[$];
    step_t plan[$];
    obs_t  mon_exp;
    int    vectors       = 0;
    int    miscompares   = 0;
    int    done_seen     = 0;
    int    done_expected = 0;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .done      (done),
        .illegal   (illegal),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_dut();
        obs_t o;
        o.st  = state;
        o.pcw = PCWrite;
        o.adr = AdrSrc;
        o.mw  = MemWrite;
        o.irw = IRWrite;
        o.rw  = RegWrite;
        o.dn  = done;
        o.ill = illegal;
        o.rs  = ResultSrc;
        o.asa = ALUSrcA;
        o.asb = ALUSrcB;
        o.aop = ALUOp;
        return o;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_output(input string name, input obs_t act, input obs_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: actual state=%0d vec=%h, required state=%0d vec=%h",
                     name, $time, act.st, act, req.st, req);
        end
    endtask

    // Monitor: pops one expectation per clock and compares it mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check_output($sformatf("cycle_state%0d", mon_exp.st), sample_dut(), mon_exp);
        end
        if (!rst && done) begin
            done_seen++;
        end
    end

    task automatic add_step(input logic mr, input logic z, input obs_t o);
        step_t s;
        s.mr = mr;
        s.z  = z;
        s.o  = o;
        plan.push_back(s);
    endtask

    task automatic add_aluwb();
        obs_t o;
        o    = blank(4'd7);
        o.rw = 1'b1;
        o.dn = 1'b1;
        add_step(rnd_bit(), rnd_bit(), o);
    endtask

    // Reference model: expands one instruction into its expected cycle sequence
    task automatic build_plan(input logic [6:0] op, input int fw, input int mw,
                              input logic zbr, output bit bad);
        obs_t o;
        plan.delete();
        bad = 1'b0;
        for (int i = 0; i < fw; i++) begin
            o     = blank(4'd0);
            o.asb = 2'b10;
            o.rs  = 2'b10;
            add_step(1'b0, rnd_bit(), o);
        end
        o     = blank(4'd0);
        o.asb = 2'b10;
        o.rs  = 2'b10;
        o.irw = 1'b1;
        o.pcw = 1'b1;
        add_step(1'b1, rnd_bit(), o);
        o     = blank(4'd1);
        o.asa = 2'b01;
        o.asb = 2'b01;
        add_step(rnd_bit(), rnd_bit(), o);
        case (op)
            7'b0000011, 7'b0100011: begin
                o     = blank(4'd2);
                o.asa = 2'b10;
                o.asb = 2'b01;
                add_step(rnd_bit(), rnd_bit(), o);
                if (op == 7'b0000011) begin
                    o     = blank(4'd3);
                    o.adr = 1'b1;
                    for (int i = 0; i < mw; i++) add_step(1'b0, rnd_bit(), o);
                    add_step(1'b1, rnd_bit(), o);
                    o    = blank(4'd4);
                    o.rs = 2'b01;
                    o.rw = 1'b1;
                    o.dn = 1'b1;
                    add_step(rnd_bit(), rnd_bit(), o);
                end else begin
                    o     = blank(4'd5);
                    o.adr = 1'b1;
                    o.mw  = 1'b1;
                    for (int i = 0; i < mw; i++) add_step(1'b0, rnd_bit(), o);
                    o.dn  = 1'b1;
                    add_step(1'b1, rnd_bit(), o);
                end
            end
            7'b0110011: begin
                o     = blank(4'd6);
                o.asa = 2'b10;
                o.aop = 2'b10;
                add_step(rnd_bit(), rnd_bit(), o);
                add_aluwb();
            end
            7'b0010011: begin
                o     = blank(4'd8);
                o.asa = 2'b10;
                o.asb = 2'b01;
                o.aop = 2'b10;
                add_step(rnd_bit(), rnd_bit(), o);
                add_aluwb();
            end
            7'b1101111: begin
                o     = blank(4'd9);
                o.asa = 2'b01;
                o.asb = 2'b10;
                o.pcw = 1'b1;
                add_step(rnd_bit(), rnd_bit(), o);
                add_aluwb();
            end
            7'b1100011: begin
                o     = blank(4'd10);
                o.asa = 2'b10;
                o.aop = 2'b01;
                o.pcw = zbr;
                o.dn  = 1'b1;
                add_step(rnd_bit(), zbr, o);
            end
            default: begin
                bad = 1'b1;
                o     = blank(4'd11);
                o.ill = 1'b1;
                for (int i = 0; i < 10 + mw; i++) add_step(rnd_bit(), rnd_bit(), o);
            end
        endcase
    endtask

    // Async reset between edges: outputs must clear before the next clock
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check_output("async_reset", sample_dut(), blank(4'd0));
        @(posedge clk);
        #1;
        check_output("held_reset", sample_dut(), blank(4'd0));
        rst       = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Driver: plays the plan, queuing each expectation before its cycle is sampled
    task automatic apply_stimulus(input logic [6:0] op, input int abort_at, input bit bad);
        bit aborted;
        aborted = 1'b0;
        Op = op;
        for (int k = 0; k < plan.size(); k++) begin
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            mem_ready = plan[k].mr;
            Zero      = plan[k].z;
            exp_q.push_back(plan[k].o);
            if (plan[k].o.dn) done_expected++;
            @(posedge clk);
            #1;
        end
        if (aborted || bad) reset_pulse();
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic z, input int abort_at, input bit tie_ready);
        bit bad;
        step_t s;
        build_plan(op, fw, mw, z, bad);
        if (tie_ready) begin
            for (int k = 0; k < plan.size(); k++) begin
                s          = plan[k];
                s.mr       = 1'b1;
                plan[k]    = s;
            end
        end
        apply_stimulus(op, abort_at, bad);
    endtask

    initial begin
        logic [6:0] op_tab [0:5];
        logic [6:0] op;
        bit         bad;
        int         abort_at;
        op_tab[0] = 7'b0000011;
        op_tab[1] = 7'b0100011;
        op_tab[2] = 7'b0110011;
        op_tab[3] = 7'b0010011;
        op_tab[4] = 7'b1101111;
        op_tab[5] = 7'b1100011;

        rst       = 1'b1;
        Op        = 7'd0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset_state", sample_dut(), blank(4'd0));
        rst = 1'b0;

        $display("[TB] directed instructions");
        run_instr(7'b0110011, 0, 0, 1'b0, -1, 1'b1);
        run_instr(7'b0000011, 2, 2, 1'b0, -1, 1'b0);
        run_instr(7'b1100011, 0, 0, 1'b1, -1, 1'b0);
        run_instr(7'b1100011, 1, 0, 1'b0, -1, 1'b0);
        run_instr(7'b0100011, 0, 3, 1'b0, -1, 1'b0);
        run_instr(7'b1101111, 1, 0, 1'b0, -1, 1'b0);
        run_instr(7'b0010011, 0, 0, 1'b0, -1, 1'b0);
        run_instr(7'b1111111, 0, 2, 1'b0, -1, 1'b0);
        run_instr(7'b0000011, 1, 3, 1'b0, 5, 1'b0);
        run_instr(7'b0110011, 0, 0, 1'b0, -1, 1'b0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 7'($urandom_range(0, 127));
            end else begin
                op = op_tab[$urandom_range(0, 5)];
            end
            build_plan(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit(), bad);
            abort_at = -1;
            if ($urandom_range(0, 9) == 0) begin
                abort_at = $urandom_range(1, plan.size() - 1);
            end
            apply_stimulus(op, abort_at, bad);
        end
        run_instr(7'b0110011, 0, 0, 1'b0, -1, 1'b0);

        @(negedge clk);
        vectors++;
        if (done_seen != done_expected) begin
            miscompares++;
            $display("[TB] FAIL done_count: actual %0d, required %0d", done_seen, done_expected);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
